// File: rtl/wb_display_pkg.sv
`default_nettype none
// ============================================================================
// Package     : wb_display_pkg
// Description : Shared types and constants for the wall-clock display
//               scheduler and its pixel datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_display_pkg;

    // Scheduler sequencing states
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CAPTURE    = 3'd1,
        BUILD      = 3'd2,
        WAIT_READY = 3'd3,
        COMMIT     = 3'd4
    } state_e;

    localparam int PIXEL_W = 24;
    localparam int DIGIT_W = 4;

    localparam logic PAGE_HM = 1'b0;
    localparam logic PAGE_MS = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pixel_scale.sv
`default_nettype none
// ============================================================================
// Module      : pixel_scale
// Description : Combinational GRB colour scaler. Each 8-bit channel is
//               multiplied by an 8-bit scale and the top byte of the 16-bit
//               product is kept, so a scale of 0 is always dark.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_scale
    import wb_display_pkg::*;
(
    input  logic [PIXEL_W-1:0] color_i,
    input  logic [7:0]         scale_i,
    output logic [PIXEL_W-1:0] color_o
);

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        assign color_o[8*ch +: 8] =
            8'((16'(color_i[8*ch +: 8]) * 16'(scale_i)) >> 8);
    end

endmodule
`default_nettype wire

// File: rtl/display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : display_scheduler
// Description : Once per 1 Hz tick, captures the BCD time, picks the HH:MM or
//               MM:SS page, renders one pixel per cycle into a shadow frame
//               and hands it to the WS2812 driver atomically while the driver
//               is between frames.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scheduler
    import wb_display_pkg::*;
#(
    parameter int          NUM_LEDS    = 16,
    parameter int          SHOW_DIGITS = 4,
    parameter int          PAGE_TICKS  = 5,
    parameter logic [23:0] COLOR_HM    = 24'hFF_FF_FF,
    parameter logic [23:0] COLOR_MS    = 24'h00_FF_FF
)
(
    input  logic                        hwclk,
    input  logic                        reset,
    input  logic                        tick_1hz,
    input  logic [23:0]                 time_bcd,
    input  logic                        page_hold,
    input  logic [7:0]                  brightness,
    input  logic                        frame_ready,
    output logic [PIXEL_W*NUM_LEDS-1:0] packed_rgb_data,
    output logic                        frame_update,
    output logic                        page,
    output logic                        busy
);

    localparam int IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int DIG_BITS = SHOW_DIGITS * DIGIT_W;

    state_e                      state_q, state_d;
    logic                        pending_q;
    logic [7:0]                  count_q;
    logic                        page_q;
    logic [DIG_BITS-1:0]         digits_q;
    logic [PIXEL_W-1:0]          color_q;
    logic [7:0]                  bright_q;
    logic [IDX_W-1:0]            idx_q;
    logic [PIXEL_W*NUM_LEDS-1:0] shadow_q;
    logic [PIXEL_W*NUM_LEDS-1:0] packed_q;
    logic                        frame_update_q;

    logic                        w_start;
    logic                        w_capture;
    logic                        w_build;
    logic                        w_commit;
    logic                        w_page_next;
    logic [7:0]                  w_count_next;
    logic [DIG_BITS-1:0]         w_digits;
    logic [PIXEL_W-1:0]          w_color_sel;
    logic [PIXEL_W-1:0]          w_scaled;
    logic [PIXEL_W-1:0]          w_pixel;

    // State register
    always_ff @(posedge hwclk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: capture, build NUM_LEDS pixels, wait for the driver, commit
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (tick_1hz || pending_q)              state_d = CAPTURE;
            CAPTURE:                                            state_d = BUILD;
            BUILD:      if (idx_q == IDX_W'(NUM_LEDS - 1))      state_d = WAIT_READY;
            WAIT_READY: if (frame_ready)                        state_d = COMMIT;
            COMMIT:                                             state_d = IDLE;
            default:                                            state_d = IDLE;
        endcase
    end

    // State-decoded strobes and status
    always_comb begin
        busy      = (state_q != IDLE);
        w_start   = (state_q == IDLE) && (tick_1hz || pending_q);
        w_capture = (state_q == CAPTURE);
        w_build   = (state_q == BUILD);
        w_commit  = (state_q == COMMIT);
    end

    // Paging decision and page-dependent digit/colour selection for the capture
    always_comb begin
        if (page_hold) begin
            w_page_next  = page_q;
            w_count_next = 8'd0;
        end else if (count_q == 8'(PAGE_TICKS - 1)) begin
            w_page_next  = ~page_q;
            w_count_next = 8'd0;
        end else begin
            w_page_next  = page_q;
            w_count_next = count_q + 8'd1;
        end
        w_digits    = (w_page_next == PAGE_HM) ? time_bcd[23 -: DIG_BITS]
                                               : time_bcd[DIG_BITS-1:0];
        w_color_sel = (w_page_next == PAGE_HM) ? COLOR_HM : COLOR_MS;
    end

    // Brightness is fixed for the whole frame, so one scaler serves every pixel
    pixel_scale u_pixel_scale (
        .color_i (color_q),
        .scale_i (bright_q),
        .color_o (w_scaled)
    );

    // Pixel k mirrors bit k of the captured digit word
    always_comb begin
        w_pixel = digits_q[idx_q] ? w_scaled : '0;
    end

    // Datapath: tick merging, capture, shadow build and atomic commit
    always_ff @(posedge hwclk) begin
        if (reset) begin
            pending_q      <= 1'b0;
            count_q        <= 8'd0;
            page_q         <= PAGE_HM;
            digits_q       <= '0;
            color_q        <= '0;
            bright_q       <= 8'd0;
            idx_q          <= '0;
            shadow_q       <= '0;
            packed_q       <= '0;
            frame_update_q <= 1'b0;
        end else begin
            if (w_start)
                pending_q <= 1'b0;
            else if (tick_1hz && (state_q != IDLE))
                pending_q <= 1'b1;

            if (w_capture) begin
                digits_q <= w_digits;
                color_q  <= w_color_sel;
                bright_q <= brightness;
                page_q   <= w_page_next;
                count_q  <= w_count_next;
                idx_q    <= '0;
            end

            if (w_build) begin
                shadow_q[idx_q*PIXEL_W +: PIXEL_W] <= w_pixel;
                idx_q                              <= idx_q + 1'b1;
            end

            frame_update_q <= w_commit;
            if (w_commit)
                packed_q <= shadow_q;
        end
    end

    assign packed_rgb_data = packed_q;
    assign frame_update    = frame_update_q;
    assign page            = page_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scheduler
// Description : Directed self-checking bench for display_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scheduler;

    logic         hwclk;
    logic         reset;
    logic         tick_1hz;
    logic [23:0]  time_bcd;
    logic         page_hold;
    logic [7:0]   brightness;
    logic         frame_ready;
    logic [383:0] packed_rgb_data;
    logic         frame_update;
    logic         page;
    logic         busy;

    int tests = 0;
    int fails = 0;

    display_scheduler dut (
        .hwclk           (hwclk),
        .reset           (reset),
        .tick_1hz        (tick_1hz),
        .time_bcd        (time_bcd),
        .page_hold       (page_hold),
        .brightness      (brightness),
        .frame_ready     (frame_ready),
        .packed_rgb_data (packed_rgb_data),
        .frame_update    (frame_update),
        .page            (page),
        .busy            (busy)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    task automatic reset_dut();
        reset       = 1'b1;
        tick_1hz    = 1'b0;
        page_hold   = 1'b0;
        brightness  = 8'hFF;
        frame_ready = 1'b1;
        time_bcd    = 24'h12_34_56;
        repeat (2) @(posedge hwclk);
        #1 reset = 1'b0;
    endtask

    // Tick is sampled on the second edge (E0); returns at E0+1
    task automatic send_tick();
        @(posedge hwclk);
        #1 tick_1hz = 1'b1;
        @(posedge hwclk);
        #1 tick_1hz = 1'b0;
    endtask

    // Cycles after E0 until frame_update is seen high; -1 on timeout
    task automatic wait_frame(output int n);
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge hwclk);
            #1;
            if (frame_update === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_frame(output int n);
        send_tick();
        wait_frame(n);
        repeat (20) @(posedge hwclk);
        #1;
    endtask

    task automatic test_reset();
        reset_dut();
        tests++; if (packed_rgb_data !== '0) begin fails++; $display("FAIL reset_packed got %h want 0", packed_rgb_data); end
        tests++; if (frame_update !== 1'b0) begin fails++; $display("FAIL reset_frame_update got %b want 0", frame_update); end
        tests++; if (page !== 1'b0) begin fails++; $display("FAIL reset_page got %b want 0", page); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_commit_timing();
        int n;
        logic [15:0] mask;
        logic [23:0] exp_px;
        reset_dut();
        send_tick();
        wait_frame(n);
        tests++; if (n !== 19) begin fails++; $display("FAIL commit_latency got %0d want 19", n); end
        tests++; if (page !== 1'b0) begin fails++; $display("FAIL commit_page got %b want 0", page); end
        // digits {1,2,3,4}: lit pixels 2,4,5,9,12 at FF*FF>>8 = FE
        mask = 16'h1234;
        for (int k = 0; k < 16; k++) begin
            exp_px = mask[k] ? 24'hFE_FE_FE : 24'h00_00_00;
            tests++;
            if (packed_rgb_data[24*k +: 24] !== exp_px) begin
                fails++;
                $display("FAIL commit_pixel%0d got %h want %h", k, packed_rgb_data[24*k +: 24], exp_px);
            end
        end
        @(posedge hwclk); #1;
        tests++; if (frame_update !== 1'b0) begin fails++; $display("FAIL commit_pulse_width got %b want 0", frame_update); end
    endtask

    task automatic test_paging();
        int n;
        logic [9:0] exp_pages;
        exp_pages = 10'b01_1111_0000;
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            run_frame(n);
            tests++;
            if (page !== exp_pages[i]) begin
                fails++;
                $display("FAIL paging_capture%0d got %b want %b", i + 1, page, exp_pages[i]);
            end
        end
    endtask

    task automatic test_page_hold();
        int n;
        reset_dut();
        run_frame(n);
        run_frame(n);
        page_hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            run_frame(n);
            tests++;
            if (page !== 1'b0) begin fails++; $display("FAIL hold_capture%0d got %b want 0", i + 1, page); end
        end
        // hold cleared the count, so a full PAGE_TICKS run is needed to toggle
        page_hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_frame(n);
            tests++;
            if (page !== (i == 4)) begin
                fails++;
                $display("FAIL hold_release%0d got %b want %b", i + 1, page, (i == 4));
            end
        end
    endtask

    task automatic test_brightness();
        int n;
        reset_dut();
        for (int i = 0; i < 4; i++) run_frame(n);
        brightness = 8'h80;
        run_frame(n);
        // MM:SS digits {3,4,5,6}; digit 0 = 6 lights pixels 1 and 2
        tests++; if (page !== 1'b1) begin fails++; $display("FAIL bright_page got %b want 1", page); end
        tests++; if (packed_rgb_data[24 +: 24] !== 24'h00_7F_7F) begin fails++; $display("FAIL bright_pixel1 got %h want 007f7f", packed_rgb_data[24 +: 24]); end
        tests++; if (packed_rgb_data[48 +: 24] !== 24'h00_7F_7F) begin fails++; $display("FAIL bright_pixel2 got %h want 007f7f", packed_rgb_data[48 +: 24]); end
        tests++; if (packed_rgb_data[0 +: 24] !== 24'h00_00_00) begin fails++; $display("FAIL bright_pixel0 got %h want 000000", packed_rgb_data[0 +: 24]); end
        brightness = 8'h00;
        run_frame(n);
        tests++; if (n !== 19) begin fails++; $display("FAIL bright0_latency got %0d want 19", n); end
        tests++; if (packed_rgb_data !== '0) begin fails++; $display("FAIL bright0_frame got %h want 0", packed_rgb_data); end
    endtask

    task automatic test_wait_ready();
        int n;
        int bad;
        logic [383:0] old;
        reset_dut();
        run_frame(n);
        old = packed_rgb_data;
        time_bcd    = 24'h98_76_54;
        frame_ready = 1'b0;
        send_tick();
        repeat (17) @(posedge hwclk);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge hwclk); #1;
            if (busy !== 1'b1 || packed_rgb_data !== old || frame_update !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL wait_hold bad_cycles got %0d want 0", bad); end
        frame_ready = 1'b1;
        @(posedge hwclk); #1;
        tests++; if (frame_update !== 1'b0) begin fails++; $display("FAIL wait_early_update got %b want 0", frame_update); end
        @(posedge hwclk); #1;
        tests++; if (frame_update !== 1'b1) begin fails++; $display("FAIL wait_update got %b want 1", frame_update); end
        // digits {9,8,7,6}: pixel0 dark, pixel1 and pixel15 lit
        tests++; if (packed_rgb_data[0 +: 24] !== 24'h0) begin fails++; $display("FAIL wait_pixel0 got %h want 000000", packed_rgb_data[0 +: 24]); end
        tests++; if (packed_rgb_data[24 +: 24] !== 24'hFE_FE_FE) begin fails++; $display("FAIL wait_pixel1 got %h want fefefe", packed_rgb_data[24 +: 24]); end
        tests++; if (packed_rgb_data[360 +: 24] !== 24'hFE_FE_FE) begin fails++; $display("FAIL wait_pixel15 got %h want fefefe", packed_rgb_data[360 +: 24]); end
        time_bcd = 24'h12_34_56;
    endtask

    task automatic test_tick_collision();
        int pulses;
        int first;
        int second;
        logic bz19;
        logic bz20;
        reset_dut();
        pulses = 0; first = -1; second = -1; bz19 = 1'bx; bz20 = 1'bx;
        send_tick();
        for (int n = 1; n <= 80; n++) begin
            @(posedge hwclk); #1;
            if (frame_update === 1'b1) begin
                pulses++;
                if (first < 0) first = n; else if (second < 0) second = n;
            end
            if (n == 19) bz19 = busy;
            if (n == 20) bz20 = busy;
            if (n == 3 || n == 7 || n == 11) tick_1hz = 1'b1;
            else tick_1hz = 1'b0;
        end
        tests++; if (pulses !== 2) begin fails++; $display("FAIL collide_pulses got %0d want 2", pulses); end
        tests++; if (first !== 19) begin fails++; $display("FAIL collide_first got %0d want 19", first); end
        tests++; if (second !== 39) begin fails++; $display("FAIL collide_second got %0d want 39", second); end
        tests++; if (bz19 !== 1'b0) begin fails++; $display("FAIL collide_idle_busy got %b want 0", bz19); end
        tests++; if (bz20 !== 1'b1) begin fails++; $display("FAIL collide_capture_busy got %b want 1", bz20); end
    endtask

    task automatic test_reset_mid_build();
        int n;
        int pulses;
        int busy_cnt;
        reset_dut();
        for (int i = 0; i < 5; i++) run_frame(n);
        tests++; if (page !== 1'b1) begin fails++; $display("FAIL midrst_pre_page got %b want 1", page); end
        send_tick();
        repeat (8) @(posedge hwclk);
        #1 reset = 1'b1;
        @(posedge hwclk); #1;
        tests++; if (packed_rgb_data !== '0) begin fails++; $display("FAIL midrst_packed got %h want 0", packed_rgb_data); end
        tests++; if (page !== 1'b0) begin fails++; $display("FAIL midrst_page got %b want 0", page); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b want 0", busy); end
        reset = 1'b0;
        pulses = 0; busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge hwclk); #1;
            if (frame_update === 1'b1) pulses++;
            if (busy === 1'b1) busy_cnt++;
        end
        tests++; if (pulses !== 0) begin fails++; $display("FAIL midrst_pulses got %0d want 0", pulses); end
        tests++; if (busy_cnt !== 0) begin fails++; $display("FAIL midrst_busy_after got %0d want 0", busy_cnt); end
    endtask

    initial begin
        test_reset();
        test_commit_timing();
        test_paging();
        test_page_hold();
        test_brightness();
        test_wait_ready();
        test_tick_collision();
        test_reset_mid_build();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
